// File: rtl/projection_box_detector.sv
// ---------------------------------------------------------------------------
// projection_box_detector
//
// Projection-histogram bounding-box finder for binarised video. One frame is
// accumulated into a per-column and a per-row foreground histogram. On the
// next frame start both histograms are swept. The first qualifying run on each
// axis becomes the box edges, and the result is published with a one-cycle
// strobe. The sweep zeroes every bin after reading it, so the next
// accumulation starts from clean histograms. One result is produced every two
// frames.
//
// Ports
//   pixelclk    sole clock
//   reset_n     synchronous active-low reset
//   i_binary    binarised pixel (IMG_WIDTH_DATA bits)
//   i_hs        hsync, not used internally
//   i_vs        vsync; a falling edge marks frame start
//   i_de        data enable
//   i_hcount    column of the current pixel
//   i_vcount    row of the current pixel
//   cfg_thresh  occupancy threshold, captured when a sweep starts
//   hcount_l/r  box left / right column
//   vcount_l/r  box top / bottom row
//   box_found   the last sweep found a valid box
//   box_valid   one-cycle pulse when a sweep result is published
// ---------------------------------------------------------------------------
module projection_box_detector #(
   parameter int IMG_W          = 1920,
   parameter int IMG_H          = 1080,
   parameter int IMG_WIDTH_DATA = 24,
   parameter int CNT_W          = 12,
   parameter int FG_BLACK       = 1,
   parameter int BORDER         = 4,
   parameter int MIN_RUN        = 4,
   parameter int H_OFF_L        = 16,
   parameter int H_OFF_R        = 22,
   parameter int V_OFF_L        = 35,
   parameter int V_OFF_R        = 43
) (
   input  logic                      pixelclk,
   input  logic                      reset_n,
   input  logic [IMG_WIDTH_DATA-1:0] i_binary,
   input  logic                      i_hs,
   input  logic                      i_vs,
   input  logic                      i_de,
   input  logic [11:0]               i_hcount,
   input  logic [11:0]               i_vcount,
   input  logic [CNT_W-1:0]          cfg_thresh,
   output logic [11:0]               hcount_l,
   output logic [11:0]               hcount_r,
   output logic [11:0]               vcount_l,
   output logic [11:0]               vcount_r,
   output logic                      box_found,
   output logic                      box_valid
);

   localparam int MAX_N = (IMG_W > IMG_H) ? IMG_W : IMG_H;
   localparam int SCW   = $clog2(MAX_N + 3) + 1;
   localparam int CAW   = $clog2(IMG_W);
   localparam int RAW   = $clog2(IMG_H);

   localparam logic [SCW-1:0]   N_M1    = SCW'(MAX_N - 1);
   localparam logic [SCW-1:0]   N_LIM   = SCW'(MAX_N);
   localparam logic [SCW-1:0]   N_P1    = SCW'(MAX_N + 1);
   localparam logic [SCW-1:0]   N_P2    = SCW'(MAX_N + 2);
   localparam logic [SCW-1:0]   W_LIM   = SCW'(IMG_W);
   localparam logic [SCW-1:0]   H_LIM   = SCW'(IMG_H);
   localparam logic [SCW-1:0]   ONE     = SCW'(1);
   localparam logic [CNT_W-1:0] SAT     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [11:0]      BRD     = 12'(BORDER);
   localparam logic [11:0]      W12     = 12'(IMG_W);
   localparam logic [11:0]      H12     = 12'(IMG_H);

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_ACCUM = 2'd2;
   localparam logic [1:0] ST_SCAN  = 2'd3;

   logic [1:0]       state;
   logic             vs_prev;
   logic             vs_fall;
   logic [SCW-1:0]   cnt;          // clear address in CLEAR, sweep cycle in SCAN
   logic [CNT_W-1:0] thresh_q;
   logic             scan_start;
   logic             unused_inputs;

   assign unused_inputs = i_hs;
   assign vs_fall       = vs_prev & ~i_vs;
   assign scan_start    = (state == ST_ACCUM) && vs_fall;

   // ---------------- pixel qualification ----------------
   logic accum_en, fg, border_ok, pix_ok, col_hit;

   // The cycle that carries the closing vs edge already belongs to the next
   // frame, so it is excluded from accumulation.
   assign accum_en  = (state == ST_ACCUM) && !vs_fall;
   assign fg        = (FG_BLACK != 0) ? (i_binary == '0) : (i_binary != '0);
   assign border_ok = (i_hcount >= BRD) && (i_vcount >= BRD);
   assign pix_ok    = accum_en && i_de && fg && border_ok;
   assign col_hit   = pix_ok && (i_hcount < W12);

   // ---------------- sweep bookkeeping ----------------
   logic           proc_phase;
   logic [SCW-1:0] proc_idx;

   // Bin k is read at sweep cycle k and evaluated at cycle k+1, when the
   // registered read data is available.
   assign proc_phase = (state == ST_SCAN) && (cnt != '0) && (cnt <= N_LIM);
   assign proc_idx   = cnt - ONE;

   // ---------------- FSM ----------------
   always_ff @(posedge pixelclk) begin
      if (!reset_n) begin
         state    <= ST_CLEAR;
         cnt      <= '0;
         vs_prev  <= 1'b0;
         thresh_q <= '0;
      end else begin
         vs_prev <= i_vs;
         case (state)
            ST_CLEAR: begin
               if (cnt == N_M1) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            ST_WAIT: begin
               if (vs_fall) state <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (vs_fall) begin
                  state    <= ST_SCAN;
                  cnt      <= '0;
                  thresh_q <= cfg_thresh;
               end
            end
            default: begin
               if (cnt == N_P2) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
         endcase
      end
   end

   // ---------------- column histogram ----------------
   logic [CNT_W-1:0] col_mem [IMG_W];
   logic [CNT_W-1:0] col_rd;
   logic             col_we;
   logic [CAW-1:0]   col_wa, col_ra;
   logic [CNT_W-1:0] col_wd;
   logic             p1_valid;
   logic [CAW-1:0]   p1_addr;

   // The read is issued on the pixel cycle and the increment is written one
   // cycle later. Adjacent pixels never share a column, so no forwarding is
   // needed.
   always_ff @(posedge pixelclk) begin
      if (!reset_n) p1_valid <= 1'b0;
      else          p1_valid <= col_hit;
      p1_addr <= i_hcount[CAW-1:0];
   end

   assign col_ra = (state == ST_SCAN) ? cnt[CAW-1:0] : i_hcount[CAW-1:0];

   always_comb begin
      col_we = 1'b0;
      col_wa = '0;
      col_wd = '0;
      if (state == ST_CLEAR) begin
         col_we = (cnt < W_LIM);
         col_wa = cnt[CAW-1:0];
      end else if (p1_valid) begin
         col_we = 1'b1;
         col_wa = p1_addr;
         col_wd = (col_rd == SAT) ? SAT : col_rd + CNT_ONE;
      end else if (proc_phase && (proc_idx < W_LIM)) begin
         col_we = 1'b1;
         col_wa = proc_idx[CAW-1:0];
      end
   end

   always_ff @(posedge pixelclk) begin
      if (col_we) col_mem[col_wa] <= col_wd;
      col_rd <= col_mem[col_ra];
   end

   // ---------------- row histogram ----------------
   logic [CNT_W-1:0] row_mem [IMG_H];
   logic [CNT_W-1:0] row_rd;
   logic             row_we;
   logic [RAW-1:0]   row_wa;
   logic [CNT_W-1:0] row_wd;
   logic [CNT_W-1:0] line_cnt;
   logic [11:0]      line_v;
   logic             line_open;
   logic             line_end;

   // A line closes on the de falling edge, or is flushed when the frame ends
   // while it is still open.
   assign line_end = (state == ST_ACCUM) && line_open && (!i_de || vs_fall);

   always_ff @(posedge pixelclk) begin
      if (!reset_n) begin
         line_open <= 1'b0;
         line_cnt  <= '0;
         line_v    <= '0;
      end else if ((state != ST_ACCUM) || line_end) begin
         line_open <= 1'b0;
         line_cnt  <= '0;
      end else if (accum_en && i_de) begin
         line_open <= 1'b1;
         line_v    <= i_vcount;
         if (pix_ok && (line_cnt != SAT)) line_cnt <= line_cnt + CNT_ONE;
      end
   end

   always_comb begin
      row_we = 1'b0;
      row_wa = '0;
      row_wd = '0;
      if (state == ST_CLEAR) begin
         row_we = (cnt < H_LIM);
         row_wa = cnt[RAW-1:0];
      end else if (line_end) begin
         row_we = (line_v < H12);
         row_wa = line_v[RAW-1:0];
         row_wd = line_cnt;
      end else if (proc_phase && (proc_idx < H_LIM)) begin
         row_we = 1'b1;
         row_wa = proc_idx[RAW-1:0];
      end
   end

   always_ff @(posedge pixelclk) begin
      if (row_we) row_mem[row_wa] <= row_wd;
      row_rd <= row_mem[cnt[RAW-1:0]];
   end

   // ---------------- per-axis run detection and edge math ----------------
   logic [CNT_W-1:0] bin      [2];
   logic [11:0]      edge_lo  [2];
   logic [11:0]      edge_hi  [2];
   logic [1:0]       axis_ok;

   assign bin[0] = col_rd;
   assign bin[1] = row_rd;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         localparam int             LEN_I  = (gi == 0) ? IMG_W : IMG_H;
         localparam int             OFF_L  = (gi == 0) ? H_OFF_L : V_OFF_L;
         localparam int             OFF_R  = (gi == 0) ? H_OFF_R : V_OFF_R;
         localparam logic [SCW-1:0] LEN_M1 = SCW'(LEN_I - 1);
         localparam logic [SCW-1:0] LEN    = SCW'(LEN_I);
         localparam logic [SCW-1:0] MR     = SCW'(MIN_RUN);
         localparam logic [12:0]    L_MAX  = 13'(LEN_I - 1);

         logic           in_run, found, ok_q;
         logic [SCW-1:0] run_start, run_len, run_end, new_len;
         logic           active, occ, last;
         logic [12:0]    l_raw, r_raw, l_c, r_c;
         logic [11:0]    lo_q, hi_q;

         assign active  = proc_phase && (proc_idx < LEN);
         assign occ     = (bin[gi] >= thresh_q);
         assign last    = (proc_idx == LEN_M1);
         assign new_len = in_run ? run_len + ONE : ONE;

         always_ff @(posedge pixelclk) begin
            if (!reset_n || scan_start) begin
               in_run    <= 1'b0;
               found     <= 1'b0;
               run_start <= '0;
               run_len   <= '0;
               run_end   <= '0;
            end else if (active && !found) begin
               if (occ) begin
                  if (!in_run) run_start <= proc_idx;
                  in_run  <= 1'b1;
                  run_len <= new_len;
                  // A run still open at the last bin ends there.
                  if (last && (new_len >= MR)) begin
                     found   <= 1'b1;
                     run_end <= proc_idx;
                  end
               end else begin
                  in_run <= 1'b0;
                  if (in_run && (run_len >= MR)) begin
                     found   <= 1'b1;
                     run_end <= proc_idx - ONE;
                  end
               end
            end
         end

         // 13-bit arithmetic; bit 12 of r_raw is the sign of end-OFF_R.
         assign l_raw = 13'(run_start) + 13'(OFF_L);
         assign r_raw = 13'(run_end) - 13'(OFF_R);
         assign l_c   = (l_raw > L_MAX) ? L_MAX : l_raw;
         assign r_c   = r_raw[12] ? 13'd0 : r_raw;

         always_ff @(posedge pixelclk) begin
            if (!reset_n) begin
               lo_q <= '0;
               hi_q <= '0;
               ok_q <= 1'b0;
            end else if ((state == ST_SCAN) && (cnt == N_P1)) begin
               lo_q <= l_c[11:0];
               hi_q <= r_c[11:0];
               ok_q <= found && (l_c <= r_c);
            end
         end

         assign edge_lo[gi] = lo_q;
         assign edge_hi[gi] = hi_q;
         assign axis_ok[gi] = ok_q;
      end
   endgenerate

   // ---------------- publish ----------------
   always_ff @(posedge pixelclk) begin
      if (!reset_n) begin
         hcount_l  <= '0;
         hcount_r  <= '0;
         vcount_l  <= '0;
         vcount_r  <= '0;
         box_found <= 1'b0;
         box_valid <= 1'b0;
      end else begin
         box_valid <= 1'b0;
         if ((state == ST_SCAN) && (cnt == N_P2)) begin
            box_valid <= 1'b1;
            if (&axis_ok) begin
               hcount_l  <= edge_lo[0];
               hcount_r  <= edge_hi[0];
               vcount_l  <= edge_lo[1];
               vcount_r  <= edge_hi[1];
               box_found <= 1'b1;
            end else begin
               box_found <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_projection_box_detector.sv
// ---------------------------------------------------------------------------
// tb_projection_box_detector
//
// Small-frame bench (40x32, 4-bit bins) for projection_box_detector. A table
// of rectangle scenes with hand-computed boxes is applied frame by frame, then
// hand-written sequences cover back-to-back frames and a reset mid-frame.
// ---------------------------------------------------------------------------
module tb_projection_box_detector;

   localparam int W = 40;
   localparam int H = 32;
   localparam int N = 40;
   localparam int NV = 10;

   logic        pixelclk = 1'b0;
   logic        reset_n  = 1'b0;
   logic [23:0] i_binary = 24'hFFFFFF;
   logic        i_hs = 1'b0;
   logic        i_vs = 1'b1;
   logic        i_de = 1'b0;
   logic [11:0] i_hcount = '0;
   logic [11:0] i_vcount = '0;
   logic [3:0]  cfg_thresh = 4'd1;
   logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
   logic        box_found, box_valid;

   always #5 pixelclk = ~pixelclk;

   projection_box_detector #(
      .IMG_W(W), .IMG_H(H), .IMG_WIDTH_DATA(24), .CNT_W(4), .FG_BLACK(1),
      .BORDER(2), .MIN_RUN(3), .H_OFF_L(2), .H_OFF_R(3), .V_OFF_L(1), .V_OFF_R(2)
   ) dut (
      .pixelclk(pixelclk), .reset_n(reset_n), .i_binary(i_binary), .i_hs(i_hs),
      .i_vs(i_vs), .i_de(i_de), .i_hcount(i_hcount), .i_vcount(i_vcount),
      .cfg_thresh(cfg_thresh), .hcount_l(hcount_l), .hcount_r(hcount_r),
      .vcount_l(vcount_l), .vcount_r(vcount_r), .box_found(box_found),
      .box_valid(box_valid)
   );

   typedef struct {
      int c0; int c1; int r0; int r1;
   } rect_t;

   typedef struct {
      rect_t a; rect_t b; int thr;
      int found; int l; int r; int vl; int vr;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   int    valid_cnt = 0;
   vec_t  vecs [NV];
   rect_t none_r, full_r, rect_a;

   always @(negedge pixelclk) if (box_valid) valid_cnt++;

   task automatic step();
      @(posedge pixelclk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_box(input string tag, input int f, input int l, input int r,
                            input int vl, input int vr);
      check({tag, "_found"}, int'(box_found), f);
      check({tag, "_l"},  int'(hcount_l), l);
      check({tag, "_r"},  int'(hcount_r), r);
      check({tag, "_vl"}, int'(vcount_l), vl);
      check({tag, "_vr"}, int'(vcount_r), vr);
   endtask

   function automatic bit in_rect(input rect_t q, input int h, input int v);
      return (h >= q.c0) && (h <= q.c1) && (v >= q.r0) && (v <= q.r1);
   endfunction

   // vs falls, then H active lines of W pixels with 4 blank cycles each.
   task automatic send_frame(input rect_t a, input rect_t b);
      i_de = 1'b0;
      i_vs = 1'b1;
      repeat (3) step();
      i_vs = 1'b0;
      repeat (3) step();
      for (int v = 0; v < H; v++) begin
         for (int h = 0; h < W; h++) begin
            i_de     = 1'b1;
            i_hcount = 12'(h);
            i_vcount = 12'(v);
            i_binary = (in_rect(a, h, v) || in_rect(b, h, v)) ? 24'h0 : 24'hFFFFFF;
            step();
         end
         i_de     = 1'b0;
         i_binary = 24'hFFFFFF;
         repeat (4) step();
      end
      i_vs = 1'b1;
   endtask

   // Starts a sweep with a vs falling edge and checks latency, pulse width
   // and the published box.
   task automatic scan_and_check(input string tag, input int f, input int l, input int r,
                                 input int vl, input int vr);
      int n;
      i_vs = 1'b1;
      repeat (2) step();
      i_vs = 1'b0;
      step();
      n = 0;
      while ((box_valid !== 1'b1) && (n < N + 20)) begin
         step();
         n++;
      end
      check({tag, "_latency"}, n, N + 3);
      check_box(tag, f, l, r, vl, vr);
      step();
      check({tag, "_valid_width"}, int'(box_valid), 0);
   endtask

   initial begin
      int v0;
      none_r = '{-1, -2, -1, -2};
      full_r = '{0, W - 1, 0, H - 1};
      rect_a = '{10, 19, 8, 15};

      //            rect a             rect b           thr f   l   r  vl  vr
      vecs[0] = '{'{10, 19, 8, 15}, none_r,            1, 1, 12, 16,  9, 13};
      vecs[1] = '{'{10, 13, 8, 20}, none_r,            1, 0, 12, 16,  9, 13};
      vecs[2] = '{none_r,            none_r,           1, 0, 12, 16,  9, 13};
      vecs[3] = '{'{3, 4, 5, 9},     '{20, 29, 5, 9},  1, 1, 22, 26,  6,  7};
      vecs[4] = '{'{30, 39, 24, 31}, none_r,           1, 1, 32, 36, 25, 29};
      vecs[5] = '{'{10, 19, 8, 15},  none_r,           9, 0, 32, 36, 25, 29};
      vecs[6] = '{'{10, 19, 8, 15},  none_r,           8, 1, 12, 16,  9, 13};
      vecs[7] = '{none_r,            none_r,           0, 1,  2, 36,  1, 29};
      vecs[8] = '{full_r,            none_r,          15, 1,  4, 36,  3, 29};
      vecs[9] = '{'{5, 12, 4, 9},    '{25, 34, 20, 27}, 1, 1, 7,  9,  5,  7};

      // Reset state.
      repeat (3) step();
      check_box("reset", 0, 0, 0, 0, 0);
      check("reset_valid", int'(box_valid), 0);
      reset_n = 1'b1;
      repeat (N + 5) step();

      // Table-driven scenes.
      for (int i = 0; i < NV; i++) begin
         cfg_thresh = 4'(vecs[i].thr);
         send_frame(vecs[i].a, vecs[i].b);
         scan_and_check($sformatf("vec%0d", i), vecs[i].found, vecs[i].l, vecs[i].r,
                        vecs[i].vl, vecs[i].vr);
         $display("vec%0d thr=%0d found=%0d box=(%0d,%0d,%0d,%0d)", i, vecs[i].thr,
                  box_found, hcount_l, hcount_r, vcount_l, vcount_r);
      end

      // Back-to-back frames: only every second frame is accumulated.
      cfg_thresh = 4'd1;
      v0 = valid_cnt;
      send_frame(full_r, none_r);
      check("b2b_f1_pulses", valid_cnt - v0, 0);
      v0 = valid_cnt;
      send_frame(none_r, none_r);
      check("b2b_f2_pulses", valid_cnt - v0, 1);
      check_box("b2b_f2", 1, 4, 36, 3, 29);
      v0 = valid_cnt;
      send_frame(none_r, none_r);
      check("b2b_f3_pulses", valid_cnt - v0, 0);
      v0 = valid_cnt;
      send_frame(none_r, none_r);
      check("b2b_f4_pulses", valid_cnt - v0, 1);
      check_box("b2b_f4", 0, 4, 36, 3, 29);
      $display("b2b frames done found=%0d", box_found);

      // Reset in the middle of an accumulated frame.
      i_vs = 1'b1;
      repeat (3) step();
      i_vs = 1'b0;
      repeat (3) step();
      for (int v = 0; v < 10; v++) begin
         for (int h = 0; h < W; h++) begin
            i_de     = 1'b1;
            i_hcount = 12'(h);
            i_vcount = 12'(v);
            i_binary = 24'h0;
            step();
         end
         i_de = 1'b0;
         repeat (4) step();
      end
      i_de    = 1'b1;
      reset_n = 1'b0;
      step();
      reset_n  = 1'b1;
      i_de     = 1'b0;
      i_binary = 24'hFFFFFF;
      i_vs     = 1'b1;
      check_box("midreset", 0, 0, 0, 0, 0);
      check("midreset_valid", int'(box_valid), 0);
      repeat (N + 5) step();
      cfg_thresh = 4'd1;
      send_frame(rect_a, none_r);
      scan_and_check("post_reset", 1, 12, 16, 9, 13);
      $display("post_reset found=%0d box=(%0d,%0d,%0d,%0d)", box_found,
               hcount_l, hcount_r, vcount_l, vcount_r);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
